// File: rtl/mem_io_ctrl.sv
// CPU-side memory controller: routes each request either to a multi-cycle SRAM
// access or to the switch/hex-display register, then returns a one-cycle ready pulse.
module mem_io_ctrl #(
  parameter int          SRAM_LATENCY = 2,
  parameter logic [15:0] IO_ADDR      = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_ena,
  input  logic        cpu_wr_ena,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_mem_ena,
  output logic        sram_wr_ena,
  input  logic [15:0] sram_rdata,
  input  logic [15:0] sw_i,
  output logic [15:0] hex_value
);

  typedef enum logic [1:0] {IDLE, SRAM_ACC, IO_ACC, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SRAM_LATENCY - 1);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        wr_reg;
  logic [15:0] sw_meta_reg;
  logic [15:0] sw_sync_reg;

  // Two-flop synchronizer for the asynchronous board switches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= sw_i;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      wr_reg       <= 1'b0;
      cpu_ready    <= 1'b0;
      cpu_rdata    <= '0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      sram_mem_ena <= 1'b0;
      sram_wr_ena  <= 1'b0;
      hex_value    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cpu_ready <= 1'b0;
          if (cpu_mem_ena) begin
            // sram_addr/sram_wdata double as the latched request for both targets
            sram_addr  <= cpu_addr;
            sram_wdata <= cpu_wdata;
            wr_reg     <= cpu_wr_ena;
            if (cpu_addr == IO_ADDR) begin
              state_reg <= IO_ACC;
            end else begin
              state_reg    <= SRAM_ACC;
              sram_mem_ena <= 1'b1;
              sram_wr_ena  <= cpu_wr_ena;
              cnt_reg      <= CNT_LOAD;
            end
          end
        end
        SRAM_ACC: begin
          if (cnt_reg == 4'd0) begin
            sram_mem_ena <= 1'b0;
            sram_wr_ena  <= 1'b0;
            if (!wr_reg) cpu_rdata <= sram_rdata;
            cpu_ready <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        IO_ACC: begin
          if (wr_reg) hex_value <= sram_wdata;
          else        cpu_rdata <= sw_sync_reg;
          cpu_ready <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          cpu_ready <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl: SRAM and I/O accesses, back-to-back requests,
// mid-access address changes and asynchronous reset during an access.
module tb_mem_io_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mem_ena, cpu_wr_ena;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic [15:0] sram_addr, sram_wdata, sram_rdata;
  logic        sram_mem_ena, sram_wr_ena;
  logic [15:0] sw_i, hex_value;
  logic [15:0] rd_fixed;

  int comps = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  // SRAM data table: two fixed locations, everything else returns rd_fixed
  always_comb begin
    sram_rdata = rd_fixed;
    if (sram_addr == 16'h0001)      sram_rdata = 16'h1111;
    else if (sram_addr == 16'h0002) sram_rdata = 16'h2222;
  end

  mem_io_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_mem_ena(cpu_mem_ena), .cpu_wr_ena(cpu_wr_ena),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_mem_ena(sram_mem_ena), .sram_wr_ena(sram_wr_ena),
    .sram_rdata(sram_rdata), .sw_i(sw_i), .hex_value(hex_value)
  );

  // Issues one request from a negedge, scrambles the CPU inputs after accept,
  // and records what the DUT did; returns at the negedge after the DONE cycle.
  task automatic run_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] alt_addr,
                            output int ready_cyc, output int en_cnt, output int wr_cnt,
                            output int bad_cnt, output logic [15:0] rdata, output logic ready_after);
    cpu_mem_ena = 1'b1; cpu_wr_ena = wr; cpu_addr = addr; cpu_wdata = wdata;
    ready_cyc = -1; en_cnt = 0; wr_cnt = 0; bad_cnt = 0; rdata = 16'hxxxx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cpu_mem_ena = 1'b0; cpu_wr_ena = ~wr; cpu_addr = alt_addr; cpu_wdata = ~wdata;
      end
      if (sram_mem_ena) begin
        en_cnt++;
        if (sram_addr !== addr || sram_wdata !== wdata) bad_cnt++;
      end
      if (sram_wr_ena) wr_cnt++;
      if (cpu_ready) begin
        ready_cyc = k; rdata = cpu_rdata;
        break;
      end
    end
    @(negedge clk);
    ready_after = cpu_ready;
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_mem_ena = 1'b0; cpu_wr_ena = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    sw_i = '0; rd_fixed = '0;
    #12;
    comps++;
    if ({cpu_ready, sram_mem_ena, sram_wr_ena} !== 3'b000) begin
      errs++; $display("FAIL reset_ctrl: got %b expected 000", {cpu_ready, sram_mem_ena, sram_wr_ena});
    end
    comps++;
    if ({cpu_rdata, hex_value, sram_addr, sram_wdata} !== 64'h0) begin
      errs++; $display("FAIL reset_data: got %h expected 0", {cpu_rdata, hex_value, sram_addr, sram_wdata});
    end
    @(negedge clk);
    reset = 1'b1;
    $display("reset released");
  endtask

  task automatic test_sram_read();
    int rc, en, wc, bad; logic [15:0] rd; logic ra;
    rd_fixed = 16'h1234;
    run_access(1'b0, 16'h0010, 16'h0000, 16'hFFEF, rc, en, wc, bad, rd, ra);
    $display("sram read 0010: ready@%0d en=%0d wr=%0d rdata=%h", rc, en, wc, rd);
    comps++; if (rc !== 3)  begin errs++; $display("FAIL rd_latency: got %0d expected 3", rc); end
    comps++; if (en !== 2)  begin errs++; $display("FAIL rd_en_cycles: got %0d expected 2", en); end
    comps++; if (wc !== 0)  begin errs++; $display("FAIL rd_wr_cycles: got %0d expected 0", wc); end
    comps++; if (bad !== 0) begin errs++; $display("FAIL rd_addr_hold: got %0d bad expected 0", bad); end
    comps++; if (rd !== 16'h1234) begin errs++; $display("FAIL rd_data: got %h expected 1234", rd); end
    comps++; if (ra !== 1'b0) begin errs++; $display("FAIL rd_ready_pulse: got %b expected 0", ra); end
  endtask

  task automatic test_sram_write();
    int rc, en, wc, bad; logic [15:0] rd; logic ra;
    run_access(1'b1, 16'h0020, 16'hBEEF, 16'hFFDF, rc, en, wc, bad, rd, ra);
    $display("sram write 0020=BEEF: ready@%0d en=%0d wr=%0d hex=%h", rc, en, wc, hex_value);
    comps++; if (rc !== 3)  begin errs++; $display("FAIL wr_latency: got %0d expected 3", rc); end
    comps++; if (en !== 2)  begin errs++; $display("FAIL wr_en_cycles: got %0d expected 2", en); end
    comps++; if (wc !== 2)  begin errs++; $display("FAIL wr_wr_cycles: got %0d expected 2", wc); end
    comps++; if (bad !== 0) begin errs++; $display("FAIL wr_addr_data: got %0d bad expected 0", bad); end
    comps++; if (ra !== 1'b0) begin errs++; $display("FAIL wr_ready_pulse: got %b expected 0", ra); end
    comps++; if (hex_value !== 16'h0000) begin errs++; $display("FAIL wr_hex: got %h expected 0000", hex_value); end
  endtask

  task automatic test_io();
    int rc, en, wc, bad; logic [15:0] rd; logic ra;
    sw_i = 16'h000B;
    repeat (3) @(negedge clk);
    run_access(1'b0, 16'hFFFF, 16'h0000, 16'h1234, rc, en, wc, bad, rd, ra);
    $display("io read FFFF: ready@%0d en=%0d rdata=%h", rc, en, rd);
    comps++; if (rc !== 2) begin errs++; $display("FAIL io_rd_latency: got %0d expected 2", rc); end
    comps++; if (en !== 0) begin errs++; $display("FAIL io_rd_sram_en: got %0d expected 0", en); end
    comps++; if (rd !== 16'h000B) begin errs++; $display("FAIL io_rd_data: got %h expected 000B", rd); end
    run_access(1'b1, 16'hFFFF, 16'h00AB, 16'h1234, rc, en, wc, bad, rd, ra);
    $display("io write FFFF=00AB: ready@%0d en=%0d hex=%h", rc, en, hex_value);
    comps++; if (rc !== 2) begin errs++; $display("FAIL io_wr_latency: got %0d expected 2", rc); end
    comps++; if (en + wc !== 0) begin errs++; $display("FAIL io_wr_sram_en: got %0d expected 0", en + wc); end
    comps++; if (hex_value !== 16'h00AB) begin errs++; $display("FAIL io_wr_hex: got %h expected 00AB", hex_value); end
  endtask

  task automatic test_wrap();
    int rc, en, wc, bad; logic [15:0] rd; logic ra;
    rd_fixed = 16'h5A5A;
    run_access(1'b1, 16'hFFFE, 16'h1357, 16'h0000, rc, en, wc, bad, rd, ra);
    $display("write FFFE=1357: ready@%0d en=%0d wr=%0d hex=%h", rc, en, wc, hex_value);
    comps++; if (en !== 2 || wc !== 2 || bad !== 0) begin
      errs++; $display("FAIL fffe_sram: got en=%0d wr=%0d bad=%0d expected 2/2/0", en, wc, bad);
    end
    comps++; if (hex_value !== 16'h00AB) begin errs++; $display("FAIL fffe_hex: got %h expected 00AB", hex_value); end
    sw_i = 16'h000C;
    repeat (3) @(negedge clk);
    run_access(1'b0, 16'hFFFF, 16'h0000, 16'h0000, rc, en, wc, bad, rd, ra);
    $display("read FFFF: ready@%0d en=%0d rdata=%h", rc, en, rd);
    comps++; if (en !== 0 || rd !== 16'h000C) begin
      errs++; $display("FAIL ffff_io: got en=%0d data=%h expected 0/000C", en, rd);
    end
    run_access(1'b0, 16'h0000, 16'h0000, 16'hFFFF, rc, en, wc, bad, rd, ra);
    $display("read 0000: ready@%0d en=%0d rdata=%h", rc, en, rd);
    comps++; if (rc !== 3 || en !== 2 || rd !== 16'h5A5A) begin
      errs++; $display("FAIL wrap_0000: got rdy=%0d en=%0d data=%h expected 3/2/5A5A", rc, en, rd);
    end
  endtask

  task automatic test_back_to_back();
    int r1, r2, nready; logic [15:0] d1, d2;
    r1 = -1; r2 = -1; nready = 0; d1 = 'x; d2 = 'x;
    cpu_mem_ena = 1'b1; cpu_wr_ena = 1'b0; cpu_addr = 16'h0001; cpu_wdata = 16'h0000;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (cpu_ready) begin
        nready++;
        if (r1 < 0) begin r1 = k; d1 = cpu_rdata; cpu_addr = 16'h0002; end
        else begin r2 = k; d2 = cpu_rdata; end
      end
      if (r1 > 0 && k == r1 + 2) cpu_mem_ena = 1'b0;
    end
    $display("back-to-back: ready@%0d data=%h, ready@%0d data=%h, pulses=%0d", r1, d1, r2, d2, nready);
    comps++; if (nready !== 2) begin errs++; $display("FAIL b2b_pulses: got %0d expected 2", nready); end
    comps++; if (r1 !== 3 || r2 !== 7) begin errs++; $display("FAIL b2b_timing: got %0d/%0d expected 3/7", r1, r2); end
    comps++; if (d1 !== 16'h1111 || d2 !== 16'h2222) begin
      errs++; $display("FAIL b2b_data: got %h/%h expected 1111/2222", d1, d2);
    end
  endtask

  task automatic test_addr_change();
    int rc, en, wc, bad; logic [15:0] rd; logic ra;
    rd_fixed = 16'hCAFE;
    run_access(1'b0, 16'h0030, 16'h0000, 16'h0040, rc, en, wc, bad, rd, ra);
    $display("addr change 0030->0040: ready@%0d en=%0d bad=%0d rdata=%h", rc, en, bad, rd);
    comps++; if (bad !== 0 || en !== 2) begin
      errs++; $display("FAIL addr_hold: got bad=%0d en=%0d expected 0/2", bad, en);
    end
    comps++; if (rd !== 16'hCAFE) begin errs++; $display("FAIL addr_data: got %h expected CAFE", rd); end
  endtask

  task automatic test_reset_mid();
    int rc, en, wc, bad, nready; logic [15:0] rd; logic ra;
    nready = 0;
    cpu_mem_ena = 1'b1; cpu_wr_ena = 1'b0; cpu_addr = 16'h0050;
    @(negedge clk);
    cpu_mem_ena = 1'b0;
    comps++; if (sram_mem_ena !== 1'b1) begin errs++; $display("FAIL mid_en_before: got %b expected 1", sram_mem_ena); end
    #2 reset = 1'b0;
    #1;
    $display("reset mid-access: sram_mem_ena=%b hex=%h rdata=%h", sram_mem_ena, hex_value, cpu_rdata);
    comps++; if (sram_mem_ena !== 1'b0) begin errs++; $display("FAIL mid_en_async: got %b expected 0", sram_mem_ena); end
    comps++; if (hex_value !== 16'h0000 || cpu_rdata !== 16'h0000) begin
      errs++; $display("FAIL mid_regs: got hex=%h rdata=%h expected 0000/0000", hex_value, cpu_rdata);
    end
    repeat (2) begin
      @(negedge clk);
      if (cpu_ready) nready++;
    end
    reset = 1'b1;
    rd_fixed = 16'h0F0F;
    run_access(1'b0, 16'h0060, 16'h0000, 16'hFF9F, rc, en, wc, bad, rd, ra);
    $display("after reset read 0060: ready@%0d en=%0d rdata=%h", rc, en, rd);
    comps++; if (nready !== 0) begin errs++; $display("FAIL mid_no_ready: got %0d expected 0", nready); end
    comps++; if (rc !== 3 || rd !== 16'h0F0F) begin
      errs++; $display("FAIL mid_resume: got rdy=%0d data=%h expected 3/0F0F", rc, rd);
    end
  endtask

  initial begin
    test_reset();
    test_sram_read();
    test_sram_write();
    test_io();
    test_wrap();
    test_back_to_back();
    test_addr_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end

endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001: Parameter SRAM_LATENCY, default 2, number of cycles sram_mem_ena is held per SRAM access (legal range 1..15).
REQ-002: Parameter IO_ADDR, default 16'hFFFF, the memory-mapped switch/hex-display address.
REQ-003: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004: reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005: cpu_mem_ena  input  1  CPU memory request, level-held by the CPU until cpu_ready.
REQ-006: cpu_wr_ena  input  1  1 = write, 0 = read; sampled with the request.
REQ-007: cpu_addr  input  16  request address.
REQ-008: cpu_wdata  input  16  write data.
REQ-009: cpu_rdata  output  16  read data, valid while cpu_ready=1.
REQ-010: cpu_ready  output  1  one-cycle completion pulse.
REQ-011: sram_addr  output  16  SRAM address.
REQ-012: sram_wdata  output  16  SRAM write data.
REQ-013: sram_mem_ena  output  1  SRAM enable.
REQ-014: sram_wr_ena  output  1  SRAM write strobe.
REQ-015: sram_rdata  input  16  SRAM read data, valid on the last enabled cycle.
REQ-016: sw_i  input  16  raw asynchronous board switches.
REQ-017: hex_value  output  16  value driven to the hex display driver.

Function
REQ-018: FSM states IDLE, SRAM_ACC, IO_ACC, DONE; reset state IDLE.
REQ-019: IDLE with cpu_mem_ena=1 -> latch cpu_addr, cpu_wdata, cpu_wr_ena; go to IO_ACC if addr==IO_ADDR, else SRAM_ACC.
REQ-020: CPU address/data/wr changes after the accept cycle have no effect on the access in progress.
REQ-021: SRAM_ACC: sram_mem_ena=1 and sram_addr/sram_wdata = latched values for exactly SRAM_LATENCY cycles; sram_wr_ena=1 on all of those cycles for writes, 0 for reads.
REQ-022: SRAM read data captured from sram_rdata on the final SRAM_ACC cycle into the read register.
REQ-023: IO_ACC lasts exactly 1 cycle; no SRAM enable; a read captures the synchronized switch value; a write loads hex_value with the latched wdata.
REQ-024: sw_i passes through a 2-flop synchronizer; reads return the synchronizer output.
REQ-025: DONE lasts 1 cycle: cpu_ready=1, cpu_rdata = read register (writes: previous value, don't-care); next state IDLE.
REQ-026: Latency from the accept edge to cpu_ready: SRAM_LATENCY+1 cycles for SRAM, 2 cycles for I/O.
REQ-027: cpu_mem_ena still high in the IDLE cycle after DONE -> treated as a new request (back-to-back allowed).
REQ-028: cpu_mem_ena deasserted mid-access -> the access still completes and cpu_ready still pulses (no abort).
REQ-029: Write to IO_ADDR never reaches SRAM; read of IO_ADDR never enables SRAM.
REQ-030: Address 16'hFFFE and all non-IO_ADDR values route to SRAM, including wrap from 16'hFFFF to 16'h0000 across consecutive requests.
REQ-031: sram_mem_ena and sram_wr_ena are 0 in every state other than SRAM_ACC.

Reset
REQ-032: reset=0 forces immediately (asynchronously): state IDLE, cpu_ready=0, sram_mem_ena=0, sram_wr_ena=0, cpu_rdata=0, hex_value=0, sram_addr=0, sram_wdata=0, synchronizer flops=0, latency counter=0.
REQ-033: Reset asserted mid-access abandons the access with no cpu_ready pulse; on release, operation resumes in IDLE.
REQ-034: Requests present on the first edge after release are accepted normally.

Verification
REQ-035: SRAM read, addr 16'h0010, sram_rdata=16'h1234, SRAM_LATENCY=2 -> sram_mem_ena high for 2 cycles, wr=0, cpu_ready pulses 3 cycles after accept with cpu_rdata=16'h1234.
REQ-036: SRAM write, addr 16'h0020, wdata 16'hBEEF -> sram_wr_ena and sram_mem_ena high for 2 cycles with sram_addr=16'h0020 and sram_wdata=16'hBEEF; cpu_ready pulses once; hex_value unchanged.
REQ-037: I/O: sw_i=16'h000B, read of 16'hFFFF -> cpu_rdata=16'h000B 2 cycles after accept with no SRAM enable; then a write of 16'h00AB to 16'hFFFF -> hex_value=16'h00AB.
REQ-038: Back-to-back: cpu_mem_ena held high through two reads, 16'h0001 then 16'h0002 -> exactly two cpu_ready pulses separated by one IDLE cycle, with correct data for each.
REQ-039: Reset mid-access: reset=0 on the 1st SRAM_ACC cycle -> sram_mem_ena drops without waiting for a clock edge, no cpu_ready pulse, hex_value=0; a request after release completes normally.
REQ-040: Address change mid-access: cpu_addr changes from 16'h0030 to 16'h0040 after accept -> sram_addr stays 16'h0030 for the whole access.
